// File: rtl/pcpi_issuer.sv
// PCPI initiator: takes one command at a time, drives it onto the PCPI request lines,
// and returns exactly one response (result, write flag or timeout) per command.
module pcpi_issuer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_timeout,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        spurious_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_pcpi_valid;
  logic [31:0]           r_pcpi_insn;
  logic [31:0]           r_pcpi_rs1;
  logic [31:0]           r_pcpi_rs2;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_data;
  logic                  r_rsp_wr;
  logic                  r_rsp_timeout;
  logic                  r_spurious;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_release;

  assign cmd_ready      = (r_state == S_IDLE);
  assign pcpi_valid     = r_pcpi_valid;
  assign pcpi_insn      = r_pcpi_insn;
  assign pcpi_rs1       = r_pcpi_rs1;
  assign pcpi_rs2       = r_pcpi_rs2;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_wr         = r_rsp_wr;
  assign rsp_timeout    = r_rsp_timeout;
  assign spurious_ready = r_spurious;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // pcpi_ready is tested before the timeout so a completion on the last
  // unclaimed cycle is reported as a result, not an abort.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pcpi_ready) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (!pcpi_wait && (r_cnt == LP_CNT_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_pcpi_valid  <= 1'b0;
      r_pcpi_insn   <= '0;
      r_pcpi_rs1    <= '0;
      r_pcpi_rs2    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_wr      <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_spurious    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pcpi_valid <= 1'b1;
        r_pcpi_insn  <= cmd_insn;
        r_pcpi_rs1   <= cmd_rs1;
        r_pcpi_rs2   <= cmd_rs2;
        r_cnt        <= '0;
      end else if (r_state == S_ISSUE) begin
        // A claimed instruction (pcpi_wait) restarts the unclaimed-cycle count.
        if (pcpi_wait)        r_cnt <= '0;
        else if (!pcpi_ready) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end

      if (w_done) begin
        r_pcpi_valid  <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_data    <= pcpi_wr ? pcpi_rd : 32'd0;
        r_rsp_wr      <= pcpi_wr;
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_pcpi_valid  <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_data    <= 32'd0;
        r_rsp_wr      <= 1'b0;
        r_rsp_timeout <= 1'b1;
      end else if (w_release) begin
        r_rsp_valid   <= 1'b0;
      end

      if (pcpi_ready && (r_state != S_ISSUE)) r_spurious <= 1'b1;
    end
  end

endmodule
